// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the 3x3 matrix-multiply datapath.
//   N_DEF / W_DEF : default matrix dimension and element width
//   ACC_W         : consumer's result width (2*W+2)
//   state_t       : loader sequencing states
//   elem_lsb()    : bit offset of element (r,c) in a flat row-major bus
package matrix_pkg;

    localparam int unsigned N_DEF = 3;
    localparam int unsigned W_DEF = 8;
    localparam int unsigned ACC_W = 2 * W_DEF + 2;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    function automatic int unsigned elem_lsb(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned n,
                                             input int unsigned w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// matrix_loader: assembles a serial element stream (A row-major, then B
// row-major) into two flat N*N*W operand buses and holds the completed pair
// with mat_valid until the consumer acknowledges.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     stream element valid
//   in_data      stream element (stored verbatim)
//   in_ready     loader can accept (0 in HOLD and during rst)
//   a_mat/b_mat  element (r,c) at bits [(r*N+c)*W +: W]
//   mat_valid    a_mat/b_mat hold a complete pair (registered)
//   mat_ack      consumer has taken the pair (ignored unless mat_valid)
//   in_last      [MATRIX_LOADER_ERR_EN] marks the final B element
//   err          [MATRIX_LOADER_ERR_EN] one-cycle framing error pulse
//
// Build option: define MATRIX_LOADER_ERR_EN to add in_last framing checks.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [N*N*W-1:0] a_mat,
    output logic [N*N*W-1:0] b_mat,
    output logic             mat_valid,
    input  logic             mat_ack
`ifdef MATRIX_LOADER_ERR_EN
    ,
    input  logic             in_last,
    output logic             err
`endif
);

    localparam int unsigned NE    = N * N;
    localparam int unsigned IDX_W = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NE*W-1:0]  a_q, a_d;
    logic [NE*W-1:0]  b_q, b_d;
    logic             mat_valid_q, mat_valid_d;
    logic             accept;
    logic             frame_err;
`ifdef MATRIX_LOADER_ERR_EN
    logic             err_q, err_d;
`endif

    assign in_ready = (state_q != HOLD) && !rst;
    assign accept   = in_valid && in_ready;

    // in_last must coincide exactly with the final B element; any other
    // combination on an accepted element aborts the frame.
`ifdef MATRIX_LOADER_ERR_EN
    assign frame_err = accept && (in_last != ((state_q == LOAD_B) && (idx_q == IDX_LAST)));
`else
    assign frame_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef MATRIX_LOADER_ERR_EN
        err_d   = 1'b0;
`endif
        if (frame_err) begin
            // Abort leaves the partially written matrices in place.
            state_d = LOAD_A;
            idx_d   = '0;
`ifdef MATRIX_LOADER_ERR_EN
            err_d   = 1'b1;
`endif
        end else if (accept) begin
            for (int unsigned e = 0; e < NE; e++) begin
                if (idx_q == IDX_W'(e)) begin
                    if (state_q == LOAD_A) begin
                        a_d[elem_lsb(e / N, e % N, N, W) +: W] = in_data;
                    end else begin
                        b_d[elem_lsb(e / N, e % N, N, W) +: W] = in_data;
                    end
                end
            end
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                state_d = (state_q == LOAD_A) ? LOAD_B : HOLD;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if ((state_q == HOLD) && mat_ack) begin
            state_d = LOAD_A;
        end
        mat_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mat_valid_q <= 1'b0;
`ifdef MATRIX_LOADER_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mat_valid_q <= mat_valid_d;
`ifdef MATRIX_LOADER_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign a_mat     = a_q;
    assign b_mat     = b_q;
    assign mat_valid = mat_valid_q;
`ifdef MATRIX_LOADER_ERR_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: self-checking bench for matrix_loader. A frame-level
// model (queue of accepted elements) predicts in_ready, mat_valid, err and
// the matrix contents; a vector table and hand sequences cover the corners.
module tb_matrix_loader;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int NE = N * N;
    localparam int FE = 2 * NE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [W-1:0]    in_data = '0;
    logic            in_ready;
    logic [NE*W-1:0] a_mat, b_mat;
    logic            mat_valid;
    logic            mat_ack = 1'b0;
`ifdef MATRIX_LOADER_ERR_EN
    logic            in_last = 1'b0;
    logic            err;
`endif

    always #5 clk = ~clk;

    matrix_loader #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .mat_valid (mat_valid),
        .mat_ack   (mat_ack)
`ifdef MATRIX_LOADER_ERR_EN
        ,
        .in_last   (in_last),
        .err       (err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [NE*W-1:0] act, input logic [NE*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_hold = 1'b0;
    bit              m_known = 1'b0;
    bit              m_err = 1'b0;
    logic [W-1:0]    m_frame[$];
    logic [NE*W-1:0] m_a = '0, m_b = '0;
    int              m_cycle = 0;

    // Inputs must be set before calling; checks in_ready mid-cycle, advances
    // one clock, updates the model, then checks registered outputs.
    task automatic step();
        bit bad;
        @(negedge clk);
        check("in_ready", in_ready, !m_hold && !rst);
        @(posedge clk);
        m_err = 1'b0;
        if (rst) begin
            m_hold  = 1'b0;
            m_frame.delete();
            m_a     = '0;
            m_b     = '0;
            m_known = 1'b1;
        end else if (m_hold) begin
            if (mat_ack) m_hold = 1'b0;
        end else if (in_valid) begin
            bad = 1'b0;
`ifdef MATRIX_LOADER_ERR_EN
            bad = (in_last != (m_frame.size() == FE - 1));
`endif
            m_known = 1'b0;
            if (bad) begin
                m_err = 1'b1;
                m_frame.delete();
            end else begin
                m_frame.push_back(in_data);
                if (m_frame.size() == FE) begin
                    for (int i = 0; i < NE; i++) begin
                        m_a[i*W +: W] = m_frame[i];
                        m_b[i*W +: W] = m_frame[NE + i];
                    end
                    m_frame.delete();
                    m_hold  = 1'b1;
                    m_known = 1'b1;
                end
            end
        end
        #1;
        m_cycle++;
        check("mat_valid", mat_valid, m_hold);
        if (m_known) begin
            check("a_mat", a_mat, m_a);
            check("b_mat", b_mat, m_b);
        end
`ifdef MATRIX_LOADER_ERR_EN
        check("err", err, m_err);
`endif
    endtask

    task automatic drive(input bit r, input bit v, input logic [W-1:0] d, input bit ack);
        rst      = r;
        in_valid = v;
        in_data  = d;
        mat_ack  = ack;
`ifdef MATRIX_LOADER_ERR_EN
        in_last  = (m_frame.size() == FE - 1);
`endif
    endtask

    task automatic send(input bit v, input logic [W-1:0] d, input bit ack);
        drive(1'b0, v, d, ack);
        step();
    endtask

    typedef struct {
        bit           rst;
        bit           v;
        logic [W-1:0] d;
        bit           ack;
        bit           exp_ready;
        bit           exp_valid;
    } vec_t;

    vec_t tbl[$];

    initial begin : main
        vec_t            t;
        int              rise[$];
        bit              prev;
        logic [NE*W-1:0] snap_a, snap_b;

        // Table: reset, frame 1..18, 5-cycle ack stall with in_valid high,
        // ack, then immediate acceptance on the following cycle.
        t = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0}; tbl.push_back(t);
        for (int k = 1; k <= FE; k++) begin
            t = '{1'b0, 1'b1, W'(k), 1'b0, 1'b1, (k == FE)}; tbl.push_back(t);
        end
        for (int k = 0; k < 5; k++) begin
            t = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1}; tbl.push_back(t);
        end
        t = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0}; tbl.push_back(t);
        t = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0}; tbl.push_back(t);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].ack);
            #2;
            check("tbl_ready", in_ready, tbl[i].exp_ready);
            step();
            check("tbl_valid", mat_valid, tbl[i].exp_valid);
            if (i == 0) begin
                check("rst_a", a_mat, '0);
                check("rst_b", b_mat, '0);
            end
            if (i == FE) begin
                check("a11", a_mat[7:0], 8'd1);
                check("a33", a_mat[71:64], 8'd9);
                check("b11", b_mat[7:0], 8'd10);
                check("b33", b_mat[71:64], 8'd18);
                snap_a = a_mat;
                snap_b = b_mat;
            end
            if (i > FE && i <= FE + 5) begin
                check("hold_a_stable", a_mat, snap_a);
                check("hold_b_stable", b_mat, snap_b);
            end
        end

        // Ack while loading is ignored; then reset after 12 elements.
        for (int k = 0; k < 4; k++) send(1'b1, W'($urandom), 1'b0);
        for (int k = 0; k < 3; k++) begin
            send(1'b0, '0, 1'b1);
            check("ack_midload_ready", in_ready, 1'b1);
        end
        for (int k = 0; k < 7; k++) send(1'b1, W'($urandom), 1'b0);
        drive(1'b1, 1'b1, 8'h77, 1'b0);
        #2;
        check("rst_ready_low", in_ready, 1'b0);
        step();
        check("rst_mid_a", a_mat, '0);
        for (int k = 0; k < FE; k++) send(1'b1, 8'hFF, 1'b0);
        check("ff_valid", mat_valid, 1'b1);
        check("ff_a", a_mat, '1);
        check("ff_b", b_mat, '1);
        send(1'b0, '0, 1'b1);

        // Continuous stream with ack held high: 19-cycle frame period.
        prev = 1'b0;
        for (int k = 0; k < 62; k++) begin
            send(1'b1, W'($urandom), 1'b1);
            if (mat_valid && !prev) rise.push_back(m_cycle);
            prev = mat_valid;
        end
        check("rise_count", 32'(rise.size()), 32'd3);
        if (rise.size() >= 3) begin
            check("period1", 32'(rise[1] - rise[0]), 32'd19);
            check("period2", 32'(rise[2] - rise[1]), 32'd19);
        end
        while (m_hold) send(1'b0, '0, 1'b1);

        // Random gaps on in_valid and random ack delays.
        for (int k = 0; k < 300; k++) begin
            send($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 2) == 0);
        end

        // Reset while holding a pair.
        for (int k = 0; k < 120 && !m_hold; k++) send(1'b1, W'($urandom), 1'b0);
        check("hold_before_rst", mat_valid, 1'b1);
        drive(1'b1, 1'b1, 8'h11, 1'b0);
        step();
        check("rst_hold_valid", mat_valid, 1'b0);

`ifdef MATRIX_LOADER_ERR_EN
        // Early in_last on element 10 aborts the frame.
        for (int k = 0; k < 10; k++) send(1'b1, W'(k), 1'b0);
        drive(1'b0, 1'b1, 8'hEE, 1'b0);
        in_last = 1'b1;
        step();
        check("err_pulse", err, 1'b1);
        check("err_no_valid", mat_valid, 1'b0);
        send(1'b0, '0, 1'b0);
        check("err_cleared", err, 1'b0);
        for (int k = 0; k < FE; k++) send(1'b1, W'(8'h40 + k), 1'b0);
        check("err_recover_valid", mat_valid, 1'b1);
        send(1'b0, '0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
